// File: rtl/bool_op_pkg.sv
// Shared definitions for the bool_op_unit block: operation codes and the
// single-bit boolean function applied across every operand bit.
package bool_op_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND    = 3'd0;
  localparam logic [OP_W-1:0] OP_OR     = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR    = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND   = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR    = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR   = 3'd5;
  localparam logic [OP_W-1:0] OP_PASS_A = 3'd6;
  localparam logic [OP_W-1:0] OP_NOT_A  = 3'd7;

  // Defined per bit so that any WIDTH can reuse it with a simple loop.
  function automatic logic bool_op_f(input logic a, input logic b,
                                     input logic [OP_W-1:0] op);
    logic r;
    case (op)
      OP_AND:    r = a & b;
      OP_OR:     r = a | b;
      OP_XOR:    r = a ^ b;
      OP_NAND:   r = ~(a & b);
      OP_NOR:    r = ~(a | b);
      OP_XNOR:   r = ~(a ^ b);
      OP_PASS_A: r = a;
      OP_NOT_A:  r = ~a;
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bool_op_fifo.sv
// Synchronous FIFO with extra-MSB pointers; full/empty derived from
// the pointer MSB comparison. Storage is reset so no X ever reaches rdata.
module bool_op_fifo #(
  parameter int DW    = 9,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [DW-1:0]    mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Guard locally as well, so a careless caller cannot corrupt the pointers.
  assign do_push = push & ~full;
  assign do_pop  = pop  & ~empty;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the storage array is reset on purpose; the head must read 0 after reset.
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/bool_op_unit.sv
// Registered bitwise logic unit: computes one of eight functions per accepted
// operand pair, queues result plus zero flag, and counts delivered results.
import bool_op_pkg::*;

module bool_op_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]  in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_zero,
  output logic [CNT_W-1:0] res_count
);

  logic [WIDTH-1:0] res_d;
  logic             zero_d;
  logic             push, pop;
  logic             full, empty;
  logic [WIDTH:0]   head;
  logic [CNT_W-1:0] res_count_q, res_count_d;

  always_comb begin
    res_d = '0;
    for (int i = 0; i < WIDTH; i++) res_d[i] = bool_op_f(in_a[i], in_b[i], in_op);
  end

  assign zero_d = ~|res_d;

  // Ready depends only on queue state (and reset), never on out_ready.
  assign in_ready  = rst_n & ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  bool_op_fifo #(
    .DW    (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata ({zero_d, res_d}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign out_zero = head[WIDTH];
  assign out_res  = head[WIDTH-1:0];

  always_comb begin
    res_count_d = res_count_q;
    if (pop) res_count_d = res_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) res_count_q <= '0;
    else        res_count_q <= res_count_d;
  end

  assign res_count = res_count_q;

endmodule

// File: tb/tb_bool_op_unit.sv
// Self-checking bench for bool_op_unit: table vectors, a result scoreboard,
// and hand-written sequences for back-pressure, streaming and reset.
module tb_bool_op_unit;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic [2:0]       in_op = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_res;
  logic             out_zero;
  logic [CNT_W-1:0] res_count;

  always #5 clk = ~clk;

  bool_op_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_zero  (out_zero),
    .res_count (res_count)
  );

  typedef struct packed {
    logic [7:0] res;
    logic       zero;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] exp;
  } vec_t;

  exp_t       sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] cnt_exp = '0;
  vec_t       vecs[9];
  logic       p;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_op(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return ~(a ^ b);
      3'd6:    return a;
      default: return ~a;
    endcase
  endfunction

  // Called at a falling edge: checks outputs, drives the next inputs, and
  // updates the scoreboard for the handshakes that happen on the coming edge.
  task automatic cycle(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op, input logic [7:0] exp_res,
                       input logic rdy, output logic pushed);
    exp_t e;
    check("out_valid", out_valid, sb.size() != 0);
    check("in_ready", in_ready, sb.size() < DEPTH);
    check("res_count", res_count, cnt_exp);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_op     = op;
    out_ready = rdy;
    if (out_valid && out_ready && sb.size() > 0) begin
      e = sb.pop_front();
      check("out_res", out_res, e.res);
      check("out_zero", out_zero, e.zero);
      cnt_exp++;
    end
    pushed = in_valid && in_ready;
    if (pushed) sb.push_back(exp_t'{res: exp_res, zero: (exp_res == 8'h00)});
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      input logic [7:0] exp_res, input logic rdy);
    logic pd;
    for (int t = 0; t < 20; t++) begin
      cycle(1'b1, a, b, op, exp_res, rdy, pd);
      if (pd) return;
    end
    check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    logic pd;
    for (int t = 0; t < 20 && sb.size() > 0; t++) cycle(1'b0, '0, '0, '0, '0, 1'b1, pd);
    check("drain_left", sb.size(), 0);
    cycle(1'b0, '0, '0, '0, '0, 1'b1, pd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hAA, 8'h0F, 3'd0, 8'h0A};
    vecs[1] = '{8'hAA, 8'h0F, 3'd1, 8'hAF};
    vecs[2] = '{8'hAA, 8'h0F, 3'd2, 8'hA5};
    vecs[3] = '{8'hAA, 8'h0F, 3'd3, 8'hF5};
    vecs[4] = '{8'hAA, 8'h0F, 3'd4, 8'h50};
    vecs[5] = '{8'hAA, 8'h0F, 3'd5, 8'h5A};
    vecs[6] = '{8'hAA, 8'h0F, 3'd6, 8'hAA};
    vecs[7] = '{8'hAA, 8'h0F, 3'd7, 8'h55};
    vecs[8] = '{8'h5A, 8'h5A, 3'd2, 8'h00};

    // Reset state
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_res_count", res_count, 0);
    check("rst_out_res", out_res, 0);
    check("rst_out_zero", out_zero, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single OR transaction, one-cycle latency
    send(8'hF0, 8'h3C, 3'd1, 8'hFC, 1'b1);
    check("t1_valid", out_valid, 1);
    check("t1_res", out_res, 8'hFC);
    check("t1_zero", out_zero, 0);
    cycle(1'b0, '0, '0, '0, '0, 1'b1, p);
    check("t1_count", res_count, 8'd1);

    // Op sweep and zero result from the table
    for (int i = 0; i < 9; i++) send(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp, 1'b1);
    drain();

    // Back-pressure: two fill the queue, the third is held
    send(8'h12, 8'h34, 3'd1, 8'h36, 1'b0);
    send(8'hFF, 8'h0F, 3'd2, 8'hF0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 8'h81, 8'h00, 3'd4, 8'h7E, 1'b0, p);
      check("t4_held", p, 0);
    end
    send(8'h81, 8'h00, 3'd4, 8'h7E, 1'b1);
    drain();

    // Continuous streaming, res_count wraps
    for (int i = 0; i < 300; i++) begin
      logic [7:0] a, b;
      logic [2:0] op;
      a  = 8'($urandom);
      b  = 8'($urandom);
      op = 3'($urandom_range(0, 7));
      cycle(1'b1, a, b, op, ref_op(a, b, op), 1'b1, p);
      check("t5_push", p, 1);
    end
    drain();

    // Asynchronous reset with two entries queued
    send(8'h0F, 8'hF0, 3'd1, 8'hFF, 1'b0);
    send(8'h0F, 8'hF0, 3'd0, 8'h00, 1'b0);
    check("t6_full", in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_out_valid", out_valid, 0);
    check("t6_res_count", res_count, 0);
    check("t6_in_ready", in_ready, 0);
    check("t6_out_res", out_res, 0);
    sb.delete();
    cnt_exp = '0;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, '0, '0, 1'b1, p);
    send(8'h3C, 8'hFF, 3'd5, 8'h3C, 1'b1);
    drain();
    check("t6_final_count", res_count, 8'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
